// File: rtl/coder_seq_pkg.sv
// coder_seq_pkg: shared encodings for the coder operation scheduler.
// Holds op / core phase codes, coder modes and their cycle budgets,
// the step-type encoding used by the step ROM, and the FSM state codes.
package coder_seq_pkg;

    localparam logic [1:0] OP_KEYGEN  = 2'd0;
    localparam logic [1:0] OP_ENC     = 2'd1;
    localparam logic [1:0] OP_DEC     = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [1:0] CORE_KEYGEN = 2'd0;
    localparam logic [1:0] CORE_ENC    = 2'd1;
    localparam logic [1:0] CORE_DEC    = 2'd2;

    localparam logic [3:0] MODE_NONE = 4'd0;
    localparam logic [3:0] MODE_1    = 4'd1;
    localparam logic [3:0] MODE_2    = 4'd2;
    localparam logic [3:0] MODE_3    = 4'd3;
    localparam logic [3:0] MODE_4    = 4'd4;
    localparam logic [3:0] MODE_5    = 4'd5;
    localparam logic [3:0] MODE_6    = 4'd6;
    localparam logic [3:0] MODE_7    = 4'd7;
    localparam logic [3:0] MODE_8    = 4'd8;

    localparam logic [6:0] BUDGET_1 = 7'd67;
    localparam logic [6:0] BUDGET_2 = 7'd67;
    localparam logic [6:0] BUDGET_3 = 7'd64;
    localparam logic [6:0] BUDGET_4 = 7'd34;
    localparam logic [6:0] BUDGET_5 = 7'd100;
    localparam logic [6:0] BUDGET_6 = 7'd64;
    localparam logic [6:0] BUDGET_7 = 7'd98;
    localparam logic [6:0] BUDGET_8 = 7'd34;

    typedef enum logic [2:0] {
        STEP_LOAD_ENC = 3'd0,
        STEP_LOAD_DEC = 3'd1,
        STEP_CODER    = 3'd2,
        STEP_CORE     = 3'd3,
        STEP_END      = 3'd4
    } step_kind_t;

    typedef struct packed {
        step_kind_t  kind;
        logic [3:0]  mode;
        logic [6:0]  budget;
        logic [1:0]  core_step;
    } step_t;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LOAD        = 3'd1;
    localparam logic [2:0] ST_CODER_ISSUE = 3'd2;
    localparam logic [2:0] ST_CODER_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP_WAIT    = 3'd4;
    localparam logic [2:0] ST_CORE        = 3'd5;
    localparam logic [2:0] ST_FINISH      = 3'd6;

    function automatic logic [6:0] mode_budget(input logic [3:0] mode);
        logic [6:0] b;
        case (mode)
            MODE_1:  b = BUDGET_1;
            MODE_2:  b = BUDGET_2;
            MODE_3:  b = BUDGET_3;
            MODE_4:  b = BUDGET_4;
            MODE_5:  b = BUDGET_5;
            MODE_6:  b = BUDGET_6;
            MODE_7:  b = BUDGET_7;
            MODE_8:  b = BUDGET_8;
            default: b = 7'd0;
        endcase
        return b;
    endfunction

    function automatic step_t mk_step(input step_kind_t kind,
                                      input logic [3:0] mode,
                                      input logic [1:0] core_step);
        step_t s;
        s.kind      = kind;
        s.mode      = mode;
        s.budget    = mode_budget(mode);
        s.core_step = core_step;
        return s;
    endfunction

endpackage

// File: rtl/coder_seq_rom.sv
// coder_seq_rom: combinational step table, (op, step index) -> step record.
// Any index past the end of an op's list reads as STEP_END.
module coder_seq_rom
    import coder_seq_pkg::*;
(
    input  logic [1:0] op,
    input  logic [2:0] idx,
    output step_t      step
);

    // Fixed per-op step lists
    always_comb begin
        step = mk_step(STEP_END, MODE_NONE, 2'd0);
        case (op)
            OP_KEYGEN: begin
                case (idx)
                    3'd0:    step = mk_step(STEP_CORE,  MODE_NONE, CORE_KEYGEN);
                    3'd1:    step = mk_step(STEP_CODER, MODE_1,    2'd0);
                    3'd2:    step = mk_step(STEP_CODER, MODE_2,    2'd0);
                    default: step = mk_step(STEP_END,   MODE_NONE, 2'd0);
                endcase
            end
            OP_ENC: begin
                case (idx)
                    3'd0:    step = mk_step(STEP_LOAD_ENC, MODE_NONE, 2'd0);
                    3'd1:    step = mk_step(STEP_CODER,    MODE_3,    2'd0);
                    3'd2:    step = mk_step(STEP_CODER,    MODE_4,    2'd0);
                    3'd3:    step = mk_step(STEP_CORE,     MODE_NONE, CORE_ENC);
                    3'd4:    step = mk_step(STEP_CODER,    MODE_5,    2'd0);
                    default: step = mk_step(STEP_END,      MODE_NONE, 2'd0);
                endcase
            end
            OP_DEC: begin
                case (idx)
                    3'd0:    step = mk_step(STEP_LOAD_DEC, MODE_NONE, 2'd0);
                    3'd1:    step = mk_step(STEP_CODER,    MODE_6,    2'd0);
                    3'd2:    step = mk_step(STEP_CODER,    MODE_7,    2'd0);
                    3'd3:    step = mk_step(STEP_CORE,     MODE_NONE, CORE_DEC);
                    3'd4:    step = mk_step(STEP_CODER,    MODE_8,    2'd0);
                    default: step = mk_step(STEP_END,      MODE_NONE, 2'd0);
                endcase
            end
            default: step = mk_step(STEP_END, MODE_NONE, 2'd0);
        endcase
    end

endmodule

// File: rtl/coder_seq.sv
// coder_seq: operation scheduler for the coder pack/unpack block.
// Runs the KeyGen / Enc / Dec step lists: load pulses, budget-timed coder
// modes, and core handshake phases. All outputs are registered.
// Optional build macro CODER_SEQ_TIMEOUT_EN adds a core handshake watchdog.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// IDLE           | waiting for start
// LOAD           | load pulse cycle
// CODER_ISSUE    | coder_active/coder_mode pulse, budget counter loaded
// CODER_WAIT     | counting down the rest of the coder budget
// GAP_WAIT       | GAP idle cycles after a load or coder step
// CORE           | core_req held until core_ack (or watchdog expiry)
// FINISH         | done pulse, back to IDLE
module coder_seq
    import coder_seq_pkg::*;
#(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       coder_active,
    output logic [3:0] coder_mode,
    output logic       load_input_Enc,
    output logic       load_input_Dec,
    output logic       core_req,
    output logic [1:0] core_step,
    input  logic       core_ack
);

    localparam logic [6:0] GAP_M1 = 7'(GAP - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] op_q, op_d;
    logic [6:0] cnt_q, cnt_d;
    logic       go;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       active_q, active_d;
    logic [3:0] mode_q, mode_d;
    logic       load_enc_q, load_enc_d;
    logic       load_dec_q, load_dec_d;
    logic       core_req_q, core_req_d;
    logic [1:0] core_step_q, core_step_d;

    logic [1:0] rom_op;
    logic [2:0] rom_idx;
    step_t      rom_step;

`ifdef CODER_SEQ_TIMEOUT_EN
    localparam logic [12:0] TIMEOUT_W = 13'(TIMEOUT);
    logic [12:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // While idle the table is addressed by the incoming op at step 0,
    // otherwise by the latched op at the step after the current one.
    assign rom_op  = (state_q == ST_IDLE) ? op   : op_q;
    assign rom_idx = (state_q == ST_IDLE) ? 3'd0 : idx_q + 3'd1;

    coder_seq_rom u_rom (
        .op   (rom_op),
        .idx  (rom_idx),
        .step (rom_step)
    );

    // Next state, counters and next output values
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        go          = 1'b0;
        err_d       = 1'b0;
        active_d    = 1'b0;
        mode_d      = MODE_NONE;
        load_enc_d  = 1'b0;
        load_dec_d  = 1'b0;
        core_req_d  = 1'b0;
        core_step_d = 2'd0;
`ifdef CODER_SEQ_TIMEOUT_EN
        wd_d        = wd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op;
                    if (op == OP_ILLEGAL) begin
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
                    end else begin
                        go = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_GAP_WAIT;
                cnt_d   = GAP_M1;
            end
            ST_CODER_ISSUE: begin
                state_d = ST_CODER_WAIT;
            end
            ST_CODER_WAIT: begin
                // Leaves as the count reaches zero, so issue + wait == budget.
                if (cnt_q <= 7'd1) begin
                    state_d = ST_GAP_WAIT;
                    cnt_d   = GAP_M1;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            ST_GAP_WAIT: begin
                if (cnt_q == 7'd0) begin
                    go = 1'b1;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            ST_CORE: begin
                if (core_ack) begin
                    go = 1'b1;
                end
`ifdef CODER_SEQ_TIMEOUT_EN
                else if (wd_q == TIMEOUT_W) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end
`endif
                else begin
                    core_req_d  = 1'b1;
                    core_step_d = core_step_q;
`ifdef CODER_SEQ_TIMEOUT_EN
                    wd_d        = wd_q + 13'd1;
`endif
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go) begin
            idx_d = rom_idx;
            case (rom_step.kind)
                STEP_LOAD_ENC: begin
                    state_d    = ST_LOAD;
                    load_enc_d = 1'b1;
                end
                STEP_LOAD_DEC: begin
                    state_d    = ST_LOAD;
                    load_dec_d = 1'b1;
                end
                STEP_CODER: begin
                    state_d  = ST_CODER_ISSUE;
                    active_d = 1'b1;
                    mode_d   = rom_step.mode;
                    cnt_d    = rom_step.budget - 7'd1;
                end
                STEP_CORE: begin
                    state_d     = ST_CORE;
                    core_req_d  = 1'b1;
                    core_step_d = rom_step.core_step;
`ifdef CODER_SEQ_TIMEOUT_EN
                    wd_d        = 13'd0;
`endif
                end
                default: begin
                    state_d = ST_FINISH;
                end
            endcase
        end
    end

    assign busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    assign done_d = (state_d == ST_FINISH);

    // State, counters and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            op_q        <= 2'd0;
            cnt_q       <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
            mode_q      <= MODE_NONE;
            load_enc_q  <= 1'b0;
            load_dec_q  <= 1'b0;
            core_req_q  <= 1'b0;
            core_step_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            active_q    <= active_d;
            mode_q      <= mode_d;
            load_enc_q  <= load_enc_d;
            load_dec_q  <= load_dec_d;
            core_req_q  <= core_req_d;
            core_step_q <= core_step_d;
        end
    end

`ifdef CODER_SEQ_TIMEOUT_EN
    // Core handshake watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= 13'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign coder_active   = active_q;
    assign coder_mode     = mode_q;
    assign load_input_Enc = load_enc_q;
    assign load_input_Dec = load_dec_q;
    assign core_req       = core_req_q;
    assign core_step      = core_step_q;

endmodule
